// File: rtl/counter_updn_param.sv
// Up/down counter with variable step, MAX_VAL modulus, wrap/saturate modes and boundary pulses.
// Optional clock-enable prescaler: define COUNTER_PRESCALE_EN.
module counter_updn_param #(
  parameter int          WIDTH    = 16,
  parameter int unsigned MAX_VAL  = 2**WIDTH-1,
  parameter int          STEP_W   = 4,
  parameter int          PRESCALE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              ld_cnt,
  input  logic              updn_cnt,
  input  logic              count_enb,
  input  logic              sat_mode,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  data_out,
  output logic              tc_max,
  output logic              tc_min,
  output logic              ovf,
  output logic              unf
);

  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   WRAP_EXT = MAX_EXT + (WIDTH+1)'(1);

  if (PRESCALE < 2) begin : g_bad_prescale
    $error("counter_updn_param: PRESCALE must be >= 2");
  end
  if ((2**STEP_W) - 1 > MAX_VAL) begin : g_bad_step
    $error("counter_updn_param: 2**STEP_W-1 must not exceed MAX_VAL");
  end

  // Returns {boundary_flag, next_value}.
  function automatic logic [WIDTH:0] count_up(input logic [WIDTH-1:0]  cur,
                                              input logic [STEP_W-1:0] s,
                                              input logic              sat);
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] wrapped;
    sum     = {1'b0, cur} + (WIDTH+1)'(s);
    wrapped = WIDTH'(sum - WRAP_EXT);
    if (sum <= MAX_EXT) return {1'b0, WIDTH'(sum)};
    else if (sat)       return {1'b1, MAX_W};
    else                return {1'b1, wrapped};
  endfunction

  function automatic logic [WIDTH:0] count_down(input logic [WIDTH-1:0]  cur,
                                                input logic [STEP_W-1:0] s,
                                                input logic              sat);
    logic [WIDTH:0]   cur_ext;
    logic [WIDTH:0]   s_ext;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] wrapped;
    cur_ext = {1'b0, cur};
    s_ext   = (WIDTH+1)'(s);
    diff    = WIDTH'(cur_ext - s_ext);
    wrapped = WIDTH'(cur_ext + WRAP_EXT - s_ext);
    if (cur_ext >= s_ext) return {1'b0, diff};
    else if (sat)         return {1'b1, {WIDTH{1'b0}}};
    else                  return {1'b1, wrapped};
  endfunction

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] din);
    if ({1'b0, din} > MAX_EXT) return MAX_W;
    else                       return din;
  endfunction

  logic             step_en;
  logic [WIDTH-1:0] cnt_nxt;
  logic             ovf_nxt;
  logic             unf_nxt;
  logic [WIDTH-1:0] cnt_p0;
  logic             ovf_p0;
  logic             unf_p0;

`ifdef COUNTER_PRESCALE_EN
  localparam int              PS_W    = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE-1);

  logic [PS_W-1:0] pre_p0;

  assign step_en = (pre_p0 == PS_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            pre_p0 <= '0;
    else if (!ld_cnt)   pre_p0 <= '0;
    else if (count_enb) pre_p0 <= step_en ? '0 : pre_p0 + PS_W'(1);
  end
`else
  assign step_en = 1'b1;
`endif

  // Stage p0 input: next value and boundary flags.
  always_comb begin
    cnt_nxt = cnt_p0;
    ovf_nxt = 1'b0;
    unf_nxt = 1'b0;
    if (!ld_cnt) begin
      cnt_nxt = clamp_load(data_in);
    end else if (count_enb && step_en) begin
      if (updn_cnt) {ovf_nxt, cnt_nxt} = count_up(cnt_p0, step, sat_mode);
      else          {unf_nxt, cnt_nxt} = count_down(cnt_p0, step, sat_mode);
    end
`ifndef SYNTHESIS
    if ($isunknown({ld_cnt, count_enb})) cnt_nxt = 'x;
`endif
  end

  // Stage p0 register: counter value and one-cycle boundary pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_p0 <= '0;
      ovf_p0 <= 1'b0;
      unf_p0 <= 1'b0;
    end else begin
      cnt_p0 <= cnt_nxt;
      ovf_p0 <= ovf_nxt;
      unf_p0 <= unf_nxt;
    end
  end

  assign data_out = cnt_p0;
  assign ovf      = ovf_p0;
  assign unf      = unf_p0;
  assign tc_max   = (cnt_p0 == MAX_W);
  assign tc_min   = (cnt_p0 == '0);

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!$isunknown({ld_cnt, count_enb}))
        else $error("counter_updn_param: ld_cnt/count_enb unknown while out of reset");
    end
  end
`endif

endmodule

// File: doc/counter_updn_param.md
Name: counter_updn_param

Overview:
- Parametrised up/down counter with variable step, programmable terminal value, wrap or saturate mode, and boundary flags.
- Next-generation general counter for the design. Replaces fixed 16-bit up/down counting with a configurable-width, modulus-limited counter.
- Used for timers, address generators and FIFO occupancy tracking.
- All state is in a single clock domain.

Parameters:
- WIDTH, 16, counter width in bits.
- MAX_VAL, 2**WIDTH-1, terminal count. Valid range is 0..MAX_VAL. Constraint: 2**STEP_W-1 <= MAX_VAL.
- STEP_W, 4, width of the step input.
- PRESCALE, 4, prescaler divide ratio. Used only when COUNTER_PRESCALE_EN is defined. Must be >= 2.

Ports:
- clk  in  1  clock, rising edge active.
- rst  in  1  reset, asynchronous, active-high.
- data_in  in  WIDTH  load value.
- ld_cnt  in  1  synchronous load, active-low.
- updn_cnt  in  1  direction: 1 = up, 0 = down.
- count_enb  in  1  count enable, active-high.
- sat_mode  in  1  boundary mode: 0 = wrap, 1 = saturate.
- step  in  STEP_W  increment/decrement amount.
- data_out  out  WIDTH  counter value, registered.
- tc_max  out  1  combinational: data_out == MAX_VAL.
- tc_min  out  1  combinational: data_out == 0.
- ovf  out  1  registered one-cycle pulse on an up-count boundary event.
- unf  out  1  registered one-cycle pulse on a down-count boundary event.

Behaviour:
- Reset: rst high immediately (no clock edge needed) forces data_out=0, ovf=0, unf=0, prescaler=0. Therefore tc_min=1, and tc_max=1 only if MAX_VAL=0.
  - Reset asserted mid-count aborts the operation. The first count after deassertion starts from 0.
- Priority per rising clk edge: rst > load (ld_cnt=0) > count (count_enb=1) > hold.
- Load:
  - data_out <= min(data_in, MAX_VAL). data_in above MAX_VAL is clamped.
  - count_enb, updn_cnt and step are ignored on a load cycle.
  - ovf=unf=0 on a load cycle. Load clears the prescaler.
- Count up, with s=step:
  - sum computed in WIDTH+1 bits.
  - If data_out+s <= MAX_VAL: data_out <= data_out+s.
  - Else, wrap mode: data_out <= data_out+s-(MAX_VAL+1), and ovf=1 on the next cycle.
  - Else, saturate mode: data_out <= MAX_VAL, and ovf=1 on the next cycle. This includes attempts made while already at MAX_VAL with s>0.
- Count down:
  - If data_out >= s: data_out <= data_out-s.
  - Else, wrap mode: data_out <= data_out+(MAX_VAL+1)-s, and unf=1.
  - Else, saturate mode: data_out <= 0, and unf=1.
- step=0 with count_enb=1: value holds, ovf=unf=0.
- ovf/unf timing: registered alongside data_out, so they are high for exactly the cycle in which the post-event value is presented. They clear on the next edge unless another boundary event occurs.
- Hold: all registers unchanged; ovf=unf=0.
- Latency: one clock from a qualifying edge to data_out, ovf and unf. tc_max and tc_min follow data_out combinationally with zero latency.
- X-safety: if count_enb or ld_cnt is X/Z while rst=0, data_out goes X in simulation; an assertion flags this.

Optional Feature:
- Macro: COUNTER_PRESCALE_EN.
- When defined:
  - An internal prescaler of width clog2(PRESCALE) increments on each count_enb=1 cycle that is not a load.
  - The counter steps only on the cycle in which the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - count_enb=0 holds the prescaler. Load and rst clear it.
  - ovf/unf are generated only on actual steps.
- When undefined:
  - No prescaler logic is present.
  - The counter steps on every count_enb=1 cycle.
  - The PRESCALE parameter is ignored.

Test Plan:
- Bench parameters for all scenarios: WIDTH=16, MAX_VAL=999, STEP_W=4.
- Async reset: counting up at value 500, assert rst between edges -> data_out=0, tc_min=1, ovf=unf=0 before the next edge. Deassert and count up by 1 -> 1.
- Wrap up: load 995, then sat_mode=0, updn_cnt=1, step=3, count_enb=1 for 2 cycles -> 998, then 1 with ovf=1 for that cycle only. Next cycle gives 4 with ovf=0.
- Saturate down: load 2, then sat_mode=1, updn_cnt=0, step=5 for 2 cycles -> 0 with unf=1, then 0 with unf=1, tc_min=1.
- Load priority and clamp: ld_cnt=0, count_enb=1, data_in=1234 -> data_out=999, tc_max=1, ovf=0. Then ld_cnt=1, step=0, count_enb=1 -> stays 999, no flags.
- Wrap down: load 1, updn_cnt=0, step=4, sat_mode=0 -> 997 with unf=1.
- Prescale (COUNTER_PRESCALE_EN, PRESCALE=4): from 0, up, step=1, count_enb=1 for 8 cycles -> data_out=1 after cycle 4 and 2 after cycle 8. Drop count_enb for 2 cycles mid-sequence -> the step points shift by 2 cycles.
